// File: rtl/mipos_soc_onchip_mem_arbiter.sv
// Bounded round-robin arbiter sharing one single-port SRAM between CPU fetch (m0) and data (m1) ports.
// Grant is same-cycle combinational; read data returns one cycle after grant; losers see waitrequest.
module mipos_soc_onchip_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int BE_W     = DATA_W / 8,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);

  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             rv0_q, rv0_d;
  logic             rv1_q, rv1_d;

  logic req0, req1, keep, grant0, grant1;

  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    keep   = run_cnt_q < HOLD_CNT;
    grant0 = 1'b0;
    grant1 = 1'b0;
    // Nothing is granted while reset is held so the SRAM sees no stray access.
    if (!reset) begin
      if (req0 && req1) begin
        grant0 = (last_owner_q == 1'b0) ?  keep : ~keep;
        grant1 = (last_owner_q == 1'b1) ?  keep : ~keep;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = 1'b0;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end else if (grant0) begin
      mem_write = m0_write;
    end
    mem_chipselect = grant0 | grant1;
    mem_clken      = ~reset;

    m0_waitrequest   = req0 & ~grant0;
    m1_waitrequest   = req1 & ~grant1;
    m0_readdatavalid = rv0_q;
    m1_readdatavalid = rv1_q;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    run_cnt_d    = run_cnt_q;
    if (grant0 || grant1) begin
      if (grant1 == last_owner_q) begin
        if (run_cnt_q != HOLD_CNT) run_cnt_d = run_cnt_q + 1'b1;
      end else begin
        last_owner_d = grant1;
        run_cnt_d    = CNT_W'(1);
      end
    end else begin
      run_cnt_d = '0;
    end
    rv0_d = grant0 & ~m0_write;
    rv1_d = grant1 & ~m1_write;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= 1'b0;
      run_cnt_q    <= '0;
      rv0_q        <= 1'b0;
      rv1_q        <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      run_cnt_q    <= run_cnt_d;
      rv0_q        <= rv0_d;
      rv1_q        <= rv1_d;
    end
  end

endmodule

// File: tb/tb_mipos_soc_onchip_mem_arbiter.sv
// Directed bench for the two-port SRAM arbiter with a behavioural byte-lane SRAM model.
module tb_mipos_soc_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mipos_soc_onchip_mem_arbiter #(
    .ADDR_W(12), .DATA_W(32), .BE_W(4), .HOLD_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // SRAM model: contents cleared and 0x010 preloaded on the first clock seen in reset.
  logic [31:0] mem [0:4095];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[12'h010] <= 32'hDEADBEEF;
      init_done    <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  int exp_g [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int exp_h [5]  = '{1, 1, 1, 1, 0};

  initial begin
    reset = 1'b1;
    m0_address = 12'h000; m1_address = 12'h000;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = 32'h0; m1_writedata = 32'h0;
    idle_all();
    m0_read = 1'b1; m1_write = 1'b1;

    // Reset state with both ports requesting
    @(negedge clk);
    chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    chk("rst_cs", 32'(mem_chipselect), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_clken", 32'(mem_clken), 32'd0);
    chk("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    next_cycle();

    // Single read by m1
    reset = 1'b0;
    idle_all();
    m1_read = 1'b1; m1_address = 12'h010;
    @(negedge clk);
    chk("sr_m1_wait", 32'(m1_waitrequest), 32'd0);
    chk("sr_cs", 32'(mem_chipselect), 32'd1);
    chk("sr_addr", 32'(mem_address), 32'h010);
    chk("sr_clken", 32'(mem_clken), 32'd1);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("sr_m1_rdv", 32'(m1_readdatavalid), 32'd1);
    chk("sr_m1_data", m1_readdata, 32'hDEADBEEF);
    chk("sr_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    next_cycle();

    // Contention from reset: expect 4 grants each, alternating
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = 12'h010;
    m1_read = 1'b1; m1_address = 12'h030;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("ct_m0_wait[%0d]", i), 32'(m0_waitrequest), (exp_g[i] == 1) ? 32'd1 : 32'd0);
      chk($sformatf("ct_m1_wait[%0d]", i), 32'(m1_waitrequest), (exp_g[i] == 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk($sformatf("ct_m0_rdv[%0d]", i), 32'(m0_readdatavalid), (exp_g[i-1] == 0) ? 32'd1 : 32'd0);
        chk($sformatf("ct_m1_rdv[%0d]", i), 32'(m1_readdatavalid), (exp_g[i-1] == 1) ? 32'd1 : 32'd0);
        chk($sformatf("ct_data[%0d]", i), m0_readdata, (exp_g[i-1] == 0) ? 32'hDEADBEEF : 32'h0);
      end
      next_cycle();
    end

    // Byte-lane write by m0, then read back by m1
    idle_all();
    m0_write = 1'b1; m0_address = 12'h020; m0_writedata = 32'h11223344; m0_byteenable = 4'b0101;
    @(negedge clk);
    chk("bw_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("bw_mem_write", 32'(mem_write), 32'd1);
    chk("bw_be", 32'(mem_byteenable), 32'h5);
    next_cycle();
    idle_all();
    m1_read = 1'b1; m1_address = 12'h020;
    @(negedge clk);
    chk("bw_no_rdv", 32'(m0_readdatavalid), 32'd0);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("bw_m1_rdv", 32'(m1_readdatavalid), 32'd1);
    chk("bw_data", m1_readdata, 32'h00220044);
    next_cycle();

    // Write by m1 then immediate read by m0 of the same word
    m1_write = 1'b1; m1_address = 12'h7FF; m1_writedata = 32'hA5A5A5A5; m1_byteenable = 4'hF;
    @(negedge clk);
    chk("wr_m1_wait", 32'(m1_waitrequest), 32'd0);
    next_cycle();
    idle_all();
    m0_read = 1'b1; m0_address = 12'h7FF;
    @(negedge clk);
    chk("wr_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("wr_m1_no_rdv", 32'(m1_readdatavalid), 32'd0);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("wr_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    chk("wr_m0_data", m0_readdata, 32'hA5A5A5A5);
    next_cycle();

    // Read and write together: write takes precedence
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 12'h040;
    m0_writedata = 32'h12345678; m0_byteenable = 4'hF;
    @(negedge clk);
    chk("rw_mem_write", 32'(mem_write), 32'd1);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("rw_no_rdv", 32'(m0_readdatavalid), 32'd0);
    next_cycle();

    // Reset pulsed between a read grant and its valid
    m0_read = 1'b1; m0_address = 12'h010;
    @(negedge clk);
    chk("mr_m0_wait", 32'(m0_waitrequest), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("mr_cs", 32'(mem_chipselect), 32'd0);
    chk("mr_m0_wait_rst", 32'(m0_waitrequest), 32'd1);
    next_cycle();
    chk("mr_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    reset = 1'b0;
    m1_read = 1'b1; m1_address = 12'h030;
    @(negedge clk);
    chk("mr_m0_rdv2", 32'(m0_readdatavalid), 32'd0);
    chk("mr_first_m0", 32'(m0_waitrequest), 32'd0);
    chk("mr_first_m1", 32'(m1_waitrequest), 32'd1);
    next_cycle();

    // m1 granted twice, idle gap, then contention restarts m1's burst
    idle_all();
    m1_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("ig_pre_m1_wait[%0d]", i), 32'(m1_waitrequest), 32'd0);
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    chk("ig_idle_cs", 32'(mem_chipselect), 32'd0);
    next_cycle();
    m0_read = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("ig_m0_wait[%0d]", i), 32'(m0_waitrequest), (exp_h[i] == 1) ? 32'd1 : 32'd0);
      chk($sformatf("ig_m1_wait[%0d]", i), 32'(m1_waitrequest), (exp_h[i] == 0) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle_all();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mipos_soc_onchip_mem_arbiter.md
# mipos_soc_onchip_mem_arbiter

Two-requester arbiter that shares the single-port on-chip SRAM (32-bit words, 12-bit word address, byte enables, 1-cycle read latency) between the CPU instruction-fetch port (m0) and data port (m1). It grants at most one access per clock using bounded round-robin: a master keeps the port for up to HOLD_MAX consecutive grants while the other waits. Requesters see Avalon-MM style waitrequest/readdatavalid; the arbiter drives the memory's address/byteenable/chipselect/write/writedata and clock-enable directly.

## Interface
- ADDR_W, 12, word address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- HOLD_MAX, 4, max consecutive grants to one master while the other requests (>=1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes for writes (ignored on reads)
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request (read and write both high: write wins)
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  request held off this cycle
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- m0_readdata / m1_readdata  out  DATA_W  both driven from mem_readdata
- mem_address  out  ADDR_W; mem_byteenable  out  BE_W; mem_writedata  out  DATA_W
- mem_chipselect  out  1; mem_write  out  1; mem_clken  out  1
- mem_readdata  in  DATA_W  memory q (valid the cycle after address is sampled)

## Operation
- reqN = mN_read | mN_write. Grant is combinational from reqN and registered state {last_owner, run_cnt}.
- Arbitration per cycle: only one req -> it is granted; both -> last_owner granted if run_cnt < HOLD_MAX, else the other; none -> no grant.
- grantN => mem_chipselect=1, mem_address/byteenable/writedata = mN_*, mem_write = mN_write. No grant => mem_chipselect=0, mem_write=0, other mem_* outputs = m0 values (don't-care).
- mN_waitrequest = reqN & ~grantN. A granted request completes that cycle.
- State update on edge: grant to last_owner -> run_cnt saturating +1; grant to other -> last_owner := granted, run_cnt := 1; no grant -> run_cnt := 0, last_owner unchanged.
- run_cnt width clog2(HOLD_MAX+1), saturates at HOLD_MAX.
- Read tracking: registered rv0/rv1 set the edge after a granted read (mem_write=0) by m0/m1; mN_readdatavalid = rvN. At most one of rv0/rv1 high per cycle.
- mem_clken tied to 1 except forced 0 while reset is high.
- Writes produce no readdatavalid.

## Timing
- Reset values: last_owner=0, run_cnt=0, rv0=rv1=0; hence readdatavalid=0. While reset high: no grants, mem_chipselect=0, mem_write=0, mN_waitrequest=reqN.
- Read latency: grant in cycle N -> mN_readdatavalid=1 and mN_readdata=word in cycle N+1. Back-to-back reads sustain 1 word/cycle.
- Write: granted cycle N -> memory updated at edge ending N; a read of same address granted in N+1 returns new data.
- Reset asserted mid-read (between grant and valid): pending rv cleared asynchronously, no readdatavalid emitted.
- Simultaneous first requests after reset: m0 granted (last_owner=0, run_cnt=0).
- After an idle cycle the burst count restarts: last_owner may again take up to HOLD_MAX grants.
- Requester must hold address/data/read/write stable while waitrequest=1.

## Test plan
- Single read: m1 reads addr 0x010 (preloaded 0xDEADBEEF), m0 idle -> m1_waitrequest=0 same cycle, m1_readdatavalid=1 with 0xDEADBEEF next cycle, m0_readdatavalid stays 0.
- Contention, HOLD_MAX=4: both read continuously from reset -> grant sequence 0,0,0,0,1,1,1,1,0,… ; each waitrequest high exactly on the other's grant cycles; valids follow grants by 1 cycle.
- Byte write: m0 writes 0x11223344 byteenable 4'b0101 to addr 0x020 (was 0x00000000), then m1 reads -> 0x00220044; no readdatavalid for the write.
- Write-read ordering: m1 writes 0xA5A5A5A5 to 0x7FF at cycle N, m0 read of 0x7FF granted N+1 -> m0_readdata=0xA5A5A5A5 at N+2.
- Reset mid-read: m0 read granted, reset pulsed before next edge -> m0_readdatavalid never asserts, mem_chipselect=0 during reset, after release both-request gives grant to m0.
- Idle gap: m1 granted 2 cycles, one idle cycle, then both request -> m1 granted 4 more (run_cnt restarted), then m0.
